// File: rtl/pe256_index_decoder.sv
// pe256_index_decoder: builds an N-bit request bitmap from set/clear index words and hands it off via valid/ready
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   index word offered; accepted only while in_ready_o is high
//   in_ready_o   high in ACCUM only
//   in_idx_i     bit position to modify
//   in_set_i     1 sets the bit, 0 clears it
//   in_last_i    final index of the frame
//   out_valid_o  out_d_o holds a completed frame (HOLD)
//   out_ready_i  downstream consumes the frame
//   out_d_o      registered bitmap
//   out_count_o  population count of out_d_o
//   dup_o        pulse after an accept that did not change its bit
module pe256_index_decoder #(
  parameter int N = 256,
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_idx_i,
  input  logic         in_set_i,
  input  logic         in_last_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_d_o,
  output logic [W:0]   out_count_o,
  output logic         dup_o
);
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [W:0] ONE = 1;
  state_t state_q, state_d;
  logic [N-1:0] bitmap_q, bitmap_d;
  logic [W:0] count_q, count_d;
  logic dup_q, dup_d;
  logic acc, cur;
  assign acc = in_valid_i && state_q == ACCUM;
  assign cur = bitmap_q[in_idx_i];
  always_comb begin
    state_d = state_q;
    bitmap_d = bitmap_q;
    count_d = count_q;
    dup_d = 1'b0;
    if (acc) begin
      bitmap_d[in_idx_i] = in_set_i;
      dup_d = cur == in_set_i;
      // count only moves when the bit actually flips
      count_d = dup_d ? count_q : in_set_i ? count_q + ONE : count_q - ONE;
      state_d = in_last_i ? HOLD : ACCUM;
    end
    if (state_q == HOLD && out_ready_i) begin
      state_d = ACCUM;
      bitmap_d = '0;
      count_d = '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      bitmap_q <= '0;
      count_q <= '0;
      dup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bitmap_q <= bitmap_d;
      count_q <= count_d;
      dup_q <= dup_d;
    end
  end
  assign in_ready_o = state_q == ACCUM;
  assign out_valid_o = state_q == HOLD;
  assign out_d_o = bitmap_q;
  assign out_count_o = count_q;
  assign dup_o = dup_q;
endmodule

// File: tb/tb_pe256_index_decoder.sv
// tb_pe256_index_decoder: vector table, directed sequences and random stimulus against a frame-level model
module tb_pe256_index_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_set = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_idx = '0;
  logic in_ready, out_valid, dup;
  logic [255:0] out_d;
  logic [8:0] out_count;
  int total = 0;
  int bad = 0;
  logic [255:0] m_bm;
  logic m_hold, m_dup;
  typedef struct {
    logic v;
    logic [7:0] idx;
    logic s;
    logic l;
    logic r;
    logic e_dup;
    logic [8:0] e_cnt;
    logic e_valid;
  } vec_t;
  vec_t tbl[13];

  pe256_index_decoder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_idx_i(in_idx),
    .in_set_i(in_set), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_d_o(out_d), .out_count_o(out_count), .dup_o(dup)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    cmp({tag, "_out_d"}, out_d, m_bm);
    cmp({tag, "_count"}, 256'(out_count), 256'($countones(m_bm)));
    cmp({tag, "_valid"}, 256'(out_valid), 256'(m_hold));
    cmp({tag, "_ready"}, 256'(in_ready), 256'(!m_hold));
    cmp({tag, "_dup"}, 256'(dup), 256'(m_dup));
  endtask

  task automatic model_reset();
    m_bm = '0;
    m_hold = 1'b0;
    m_dup = 1'b0;
  endtask

  task automatic step(string tag, logic v, logic [7:0] i, logic s, logic l, logic r);
    in_valid = v;
    in_idx = i;
    in_set = s;
    in_last = l;
    out_ready = r;
    @(posedge clk);
    if (!m_hold && v) begin
      m_dup = m_bm[i] == s;
      m_bm[i] = s;
      m_hold = l;
    end else begin
      m_dup = 1'b0;
      if (m_hold && r) begin
        m_bm = '0;
        m_hold = 1'b0;
      end
    end
    #1;
    chk_model(tag);
  endtask

  initial begin
    model_reset();
    tbl[0]  = '{1, 8'd5,   1, 0, 0, 0, 9'd1, 0};
    tbl[1]  = '{1, 8'd123, 1, 0, 0, 0, 9'd2, 0};
    tbl[2]  = '{1, 8'd200, 1, 0, 0, 0, 9'd3, 0};
    tbl[3]  = '{1, 8'd123, 0, 0, 0, 0, 9'd2, 0};
    tbl[4]  = '{1, 8'd200, 1, 1, 0, 1, 9'd2, 1};
    tbl[5]  = '{0, 8'd0,   0, 0, 1, 0, 9'd0, 0};
    tbl[6]  = '{1, 8'd0,   1, 0, 0, 0, 9'd1, 0};
    tbl[7]  = '{1, 8'd255, 1, 0, 0, 0, 9'd2, 0};
    tbl[8]  = '{1, 8'd0,   0, 1, 0, 0, 9'd1, 1};
    tbl[9]  = '{0, 8'd0,   0, 0, 1, 0, 9'd0, 0};
    tbl[10] = '{1, 8'd10,  0, 1, 0, 1, 9'd0, 1};
    tbl[11] = '{0, 8'd0,   0, 0, 1, 0, 9'd0, 0};
    tbl[12] = '{1, 8'd7,   1, 0, 0, 0, 9'd1, 0};
    // reset held three cycles, then idle
    repeat (3) @(posedge clk);
    #1;
    chk_model("in_reset");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step("idle", 0, 8'd0, 0, 0, 0);
    // table: multi-bit frame, boundary frame, empty frame
    for (int k = 0; k < 13; k++) begin
      step("tbl", tbl[k].v, tbl[k].idx, tbl[k].s, tbl[k].l, tbl[k].r);
      cmp($sformatf("tbl%0d_dup", k), 256'(dup), 256'(tbl[k].e_dup));
      cmp($sformatf("tbl%0d_cnt", k), 256'(out_count), 256'(tbl[k].e_cnt));
      cmp($sformatf("tbl%0d_valid", k), 256'(out_valid), 256'(tbl[k].e_valid));
    end
    // back-to-back same index: second set is a dup
    step("b2b", 1, 8'd7, 1, 1, 0);
    cmp("b2b_dup", 256'(dup), 256'(1));
    cmp("b2b_cnt", 256'(out_count), 256'(1));
    step("b2b_rel", 0, 8'd0, 0, 0, 1);
    // single-index sweep
    for (int i = 0; i < 256; i++) begin
      step("sweep", 1, 8'(i), 1, 1, 1);
      cmp("sweep_onehot", out_d, 256'(1) << i);
      step("sweep_rel", 0, 8'd0, 0, 0, 1);
    end
    // backpressure
    step("bp", 1, 8'd42, 1, 1, 0);
    for (int k = 0; k < 10; k++) begin
      step("bp_hold", 1, 8'd9, 1, 0, 0);
      cmp("bp_bit9", 256'(out_d[9]), 256'(0));
      cmp("bp_stable", out_d, 256'(1) << 42);
    end
    step("bp_rel", 0, 8'd0, 0, 0, 1);
    cmp("bp_rel_d", out_d, 256'(0));
    cmp("bp_rel_rdy", 256'(in_ready), 256'(1));
    // full frame
    for (int i = 0; i < 256; i++) step("full", 1, 8'(i), 1, i == 255, 0);
    cmp("full_cnt", 256'(out_count), 256'(256));
    cmp("full_d", out_d, ~256'(0));
    step("full_rel", 0, 8'd0, 0, 0, 1);
    // reset while in HOLD
    step("rst_hold", 1, 8'd77, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("arst_valid", 256'(out_valid), 256'(0));
    cmp("arst_d", out_d, 256'(0));
    cmp("arst_cnt", 256'(out_count), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_rst", 1, 8'd33, 1, 1, 1);
    cmp("post_rst_onehot", out_d, 256'(1) << 33);
    step("post_rst_rel", 0, 8'd0, 0, 0, 1);
    // random traffic
    for (int k = 0; k < 3000; k++)
      step("rnd", 1'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(15) == 0, 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe256_index_decoder.md
# pe256_index_decoder

Inverse companion to the 256-bit priority encoder: it takes a stream of 8-bit bit indices and decodes each one into a bit position. Each index either sets or clears that bit in a 256-bit request bitmap. When the frame ends, the block presents the finished bitmap to the downstream priority encoder over a valid/ready handshake. It is the producer side of the encoder datapath and lets software or upstream logic build request vectors one index per cycle.

## Interface
Parameters:
- N, 256, bitmap width; must be a power of two.
- W, 8, index width; equals log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous and active-low.
- in_valid  input  1  index word offered.
- in_ready  output  1  block can accept an index; high only in ACCUM.
- in_idx  input  W  bit position to modify; all 2^W values are legal.
- in_set  input  1  1 sets bit in_idx, 0 clears bit in_idx.
- in_last  input  1  final index of the frame.
- out_valid  output  1  out_d holds a completed frame.
- out_ready  input  1  downstream consumes the frame.
- out_d  output  N  registered bitmap; visible in every state, meaningful when out_valid=1.
- out_count  output  W+1  number of ones in out_d, maintained incrementally.
- dup  output  1  registered one-cycle pulse.
  - Fires when an accepted set targets an already-set bit.
  - Fires when an accepted clear targets an already-clear bit.

## Operation
- Two-state FSM.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready. Other input fields are ignored when this condition is false.
- On accept in ACCUM:
  - bitmap[in_idx] <= in_set.
  - out_count +1 if in_set=1 and the bit was 0.
  - out_count −1 if in_set=0 and the bit was 1.
  - out_count unchanged otherwise; dup<=1 in that case.
- Accept with in_last=1: the write is applied, then state goes to HOLD.
  - An empty frame is legal: a clear-only frame with in_last yields out_d=0, out_count=0, out_valid=1.
- HOLD:
  - out_d and out_count are frozen.
  - in_valid is ignored; in_ready=0 guarantees no accept.
- HOLD with out_ready=1: frame is consumed.
  - Next cycle: bitmap=0, out_count=0, state=ACCUM.
- out_count range is 0..N; W+1 bits. It never wraps, by construction.
- dup is 0 in every cycle that follows a non-accept.

## Timing
- Reset (async assert, sync-safe deassert by system):
  - state=ACCUM, bitmap=0, out_count=0, dup=0.
  - Outputs: out_valid=0, in_ready=1.
- Reset asserted mid-frame or in HOLD discards the frame immediately. No output transfer occurs.
- Write latency: an index accepted at edge t is visible in out_d/out_count after edge t, i.e. cycle t+1.
- Frame latency: in_last accepted at edge t gives out_valid=1 in cycle t+1. out_d then includes the last write.
- Release: out_valid&&out_ready at edge t gives, in cycle t+1, out_valid=0, in_ready=1, out_d=0.
  - No same-cycle bypass: the earliest next accept is edge t+1.
  - Minimum frame period is therefore 2 cycles for a 1-index frame.
- in_ready depends only on state, never combinationally on out_ready or in_valid.
- out_valid, once high, stays high with stable out_d until consumed. This is standard valid/ready stability.
- Back-to-back accepts to the same index in consecutive cycles:
  - Each uses the bitmap value updated by the previous one. Read-after-write is through the register, with no stale read.
  - Example: set 7, set 7 gives dup on the second; count=1.
- dup is asserted in the cycle after the offending accept.

## Test plan
- Reset then idle: rst_n low 3 cycles, release, in_valid=0 for 5 cycles -> in_ready=1, out_valid=0, out_d=0, out_count=0, dup=0 throughout.
- Single-index sweep: for i=0..255, frame {idx=i, set=1, last=1} with out_ready=1 -> out_valid=1 one cycle after accept, out_d exactly one-hot at bit i, out_count=1. Feed out_d to pe256_from_64 -> q=i, v=1.
- Multi-bit frame: set 5, set 123, set 200, clear 123, set 200 (last) -> dup pulses once (on the second 200), final out_d bits {5,200}, out_count=2, encoder q=200.
- Backpressure: complete frame {set 42 last}, hold out_ready=0 for 10 cycles while driving in_valid=1 with idx=9 -> out_d stable, in_ready=0, bit 9 never set. Then out_ready=1 -> next cycle out_d=0, in_ready=1.
- Boundary: set 0, set 255, clear 0 (last) -> out_d only bit 255, out_count=1. Full frame: all 256 set then last -> out_count=256, out_d all ones.
- Reset mid-operation: assert rst_n low while in HOLD with out_d=bit 77 -> out_valid falls asynchronously, out_d=0, out_count=0. After release, the next single-index frame behaves as in the sweep test.
